// File: rtl/sky_frame_sequencer.sv
// sky_frame_sequencer: once-per-frame day/night sequencer for the sky scene.
// A frame tick (ft) fires at the first blanking line. On ft the step decision
// is made, the phase/pos state advances, and the scene outputs are reloaded
// from the next-state values. All outputs change only in the cycle after ft,
// so the visible area never sees a mid-frame change.
// Handshake note: there is no valid/ready channel here; step_req is a
// fire-and-forget pulse, captured into a sticky flag until the next ft.
module sky_frame_sequencer #(
  parameter int V_DISPLAY    = 480,
  parameter int PHASE_STEPS  = 8,
  parameter int HORIZON_ROW  = 26,
  parameter int SUN_COL_BASE = 24
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] hpos,
  input  logic [9:0] vpos,
  input  logic       run,
  input  logic       step_req,
  input  logic [1:0] speed,
  output logic [5:0] body_col,
  output logic [5:0] body_row,
  output logic [1:0] palette,
  output logic       body_is_moon,
  output logic       step_strobe,
  output logic [9:0] frame_count
);

  typedef enum logic [1:0] {DAWN = 2'd0, DAY = 2'd1, DUSK = 2'd2, NIGHT = 2'd3} phase_t;

  localparam logic [3:0] POS_LAST  = 4'(PHASE_STEPS - 1);
  localparam logic [5:0] POS_LAST6 = 6'(PHASE_STEPS - 1);
  localparam logic [5:0] STEPS6    = 6'(PHASE_STEPS);
  localparam logic [5:0] HROW      = 6'(HORIZON_ROW);
  localparam logic [5:0] COL_BASE  = 6'(SUN_COL_BASE);
  localparam logic [9:0] VTICK     = 10'(V_DISPLAY);

  phase_t     phase, phase_nx;
  logic [3:0] pos, pos_nx;
  logic [2:0] div_cnt, div_nx;
  logic       pend, pend_nx;
  logic       ft;
  logic       do_step;
  logic [3:0] limit;
  logic [5:0] col_nx, row_nx;

  // Frame tick: one cycle per frame, suppressed while reset is high.
  assign ft = (hpos == 10'd0) && (vpos == VTICK) && !reset;

  // Next-state: step decision, phase/pos advance and scene output mapping.
  always_comb begin
    pend_nx  = pend | step_req;
    div_nx   = div_cnt;
    do_step  = 1'b0;
    phase_nx = phase;
    pos_nx   = pos;
    limit    = (4'd1 << speed) - 4'd1;
    col_nx   = COL_BASE;
    row_nx   = HROW;

    if (ft) begin
      // The sticky request is consumed (or discarded) on every tick.
      pend_nx = 1'b0;
      if (run) begin
        if ({1'b0, div_cnt} >= limit) begin
          do_step = 1'b1;
          div_nx  = 3'd0;
        end else begin
          div_nx = div_cnt + 3'd1;
        end
      end else begin
        do_step = pend | step_req;
      end
    end

    if (do_step) begin
      if (pos == POS_LAST) begin
        pos_nx   = 4'd0;
        phase_nx = phase_t'(phase + 2'd1);
      end else begin
        pos_nx = pos + 4'd1;
      end
    end

    col_nx = COL_BASE + {2'b00, pos_nx};
    case (phase_nx)
      DAWN:    row_nx = HROW - {2'b00, pos_nx};
      DAY:     row_nx = HROW - STEPS6;
      DUSK:    row_nx = HROW - (POS_LAST6 - {2'b00, pos_nx});
      default: row_nx = HROW;
    endcase
  end

  // State and output registers; scene outputs load only on the frame tick.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase        <= DAWN;
      pos          <= 4'd0;
      div_cnt      <= 3'd0;
      pend         <= 1'b0;
      frame_count  <= 10'd0;
      body_col     <= COL_BASE;
      body_row     <= HROW;
      palette      <= 2'd0;
      body_is_moon <= 1'b0;
      step_strobe  <= 1'b0;
    end else begin
      pend        <= pend_nx;
      step_strobe <= ft & do_step;
      if (ft) begin
        phase        <= phase_nx;
        pos          <= pos_nx;
        div_cnt      <= div_nx;
        frame_count  <= frame_count + 10'd1;
        body_col     <= col_nx;
        body_row     <= row_nx;
        palette      <= phase_nx;
        body_is_moon <= (phase_nx == NIGHT);
      end
    end
  end

endmodule

// File: doc/sky_frame_sequencer.md
# sky_frame_sequencer

Frame-rate controller for the sky-scene pixel pipeline. Watches the beam position from the sync generator, and once per frame, at the start of vertical blanking, advances a day/night state machine. It publishes tear-free per-frame scene parameters: celestial-body tile position, palette phase and a moon flag. These feed the combinational colour logic. Pace is set by a run/pause control, a single-step request and a 2-bit speed select.

## Interface

Parameters:
- V_DISPLAY, 480: first non-visible line; the frame tick fires at hpos==0, vpos==V_DISPLAY.
- PHASE_STEPS, 8: steps per phase, 1..16.
- HORIZON_ROW, 26: tile row (pix_y[9:4]) of the horizon.
- SUN_COL_BASE, 24: tile column (pix_x[9:4]) of the body at pos 0.

Ports:
- clk  in  1  pixel clock.
- reset  in  1  synchronous, active-high.
- hpos  in  10  current beam column from the sync generator.
- vpos  in  10  current beam line from the sync generator.
- run  in  1  level; 1 = free-running, 0 = paused.
- step_req  in  1  single-cycle pulse; requests one step while paused.
- speed  in  2  frames per step = 1 << speed, giving 1/2/4/8.
- body_col  out  6  tile column of sun/moon.
- body_row  out  6  tile row of sun/moon.
- palette  out  2  equals the phase: 0 DAWN, 1 DAY, 2 DUSK, 3 NIGHT.
- body_is_moon  out  1  high in NIGHT.
- step_strobe  out  1  one-cycle pulse when a step was applied.
- frame_count  out  10  frames since reset, wraps 1023→0.

## Operation

- Frame tick ft:
  - Combinational: hpos==0 && vpos==V_DISPLAY && !reset.
  - Exactly one cycle per frame.
  - All state changes below happen only on ft, except step request capture.
- frame_count increments on every ft, modulo 1024.
- Step request capture:
  - Sticky flag pend is set by step_req on any cycle.
  - On ft, effective_req = pend | step_req; pend then clears, whether or not it was used.
- Step decision on ft:
  - run=1: if div_cnt >= (1<<speed)-1, then step and div_cnt=0; else div_cnt=div_cnt+1. Requests are discarded.
  - run=0: div_cnt holds; step iff effective_req.
  - div_cnt is 3 bits.
  - A speed change takes effect at the next ft. If the held div_cnt already meets the new limit, the step happens on that ft.
- State machine: phase in DAWN→DAY→DUSK→NIGHT→DAWN; pos in 0..PHASE_STEPS-1.
  - On a step: if pos==PHASE_STEPS-1, then pos=0 and phase advances (NIGHT wraps to DAWN); else pos=pos+1.
- Output mapping (computed from next-state values, 6-bit modulo arithmetic):
  - body_col = SUN_COL_BASE + pos.
  - body_row:
    - DAWN: HORIZON_ROW - pos
    - DAY: HORIZON_ROW - PHASE_STEPS
    - DUSK: HORIZON_ROW - (PHASE_STEPS-1-pos)
    - NIGHT: HORIZON_ROW
  - palette = phase; body_is_moon = (phase==NIGHT).
- All outputs are registered and change only in the cycle after ft, i.e. inside vblank. The visible area never sees a mid-frame change.

## Timing

- Reset values: phase=DAWN, pos=0, div_cnt=0, pend=0, frame_count=0, body_col=SUN_COL_BASE, body_row=HORIZON_ROW, palette=0, body_is_moon=0, step_strobe=0.
- Reset is sampled on the clock edge. Reset mid-frame aborts any pending request, and no ft is generated while reset is high.
- Latency:
  - ft at cycle N → outputs and step_strobe valid at cycle N+1.
  - step_strobe is high for exactly one cycle and only when a step occurred.
- Boundary cases:
  - step_req asserted on the ft cycle counts for that ft.
  - Multiple step_req pulses within one frame yield a single step.
  - step_req arriving in the cycle after ft is held for the next frame.
  - Toggling run mid-frame matters only at ft.
  - At pos wrap with phase NIGHT, the next state is DAWN with pos 0, body_row=HORIZON_ROW and body_is_moon=0.

## Test plan

- Reset then free-run, speed=0, run=1 (defaults): after 1 ft → pos 1, body_col 25, body_row 25, step_strobe one cycle; after 8 ft → DAY, palette 1, body_row 18.
- speed=2, run=1: step_strobe every 4th ft only. frame_count increases by 1 per frame, and body_col is unchanged between steps.
- run=0 with 3 step_req pulses in one frame → exactly one step at the next ft. Next frame with no request → no step_strobe.
- 32 steps at speed=0 → full cycle back to DAWN, pos 0, body_col 24, body_row 26. body_is_moon is high for steps 24..31. After 1024 frames, frame_count wraps to 0.
- Assert reset for one cycle mid-visible-area while in DUSK with pend set → all outputs at reset values next cycle; the following ft gives pos 1 with no extra step.
- Check that body_col, body_row, palette and body_is_moon never change while vpos < 480, over 64 frames with randomized run, speed and step_req.
